// File: rtl/mul_pkg.sv
// Shared definitions for the multiplier HI/LO commit stage: op encoding,
// op-class helpers and the 64-bit product type.
package mul_pkg;

  typedef logic [63:0] prod_t;
  typedef logic [2:0]  op_t;

  localparam op_t OP_MUL_S  = 3'd0;
  localparam op_t OP_MUL_U  = 3'd1;
  localparam op_t OP_MADD_S = 3'd2;
  localparam op_t OP_MADD_U = 3'd3;
  localparam op_t OP_MSUB_S = 3'd4;
  localparam op_t OP_MSUB_U = 3'd5;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } slot_state_t;

  function automatic logic is_signed_op(op_t op);
    return (op == OP_MUL_S) || (op == OP_MADD_S) || (op == OP_MSUB_S);
  endfunction

  function automatic logic is_acc_op(op_t op);
    return (op == OP_MADD_S) || (op == OP_MADD_U);
  endfunction

  function automatic logic is_sub_op(op_t op);
    return (op == OP_MSUB_S) || (op == OP_MSUB_U);
  endfunction

  function automatic logic is_reserved_op(op_t op);
    return op > OP_MSUB_U;
  endfunction

endpackage

// File: rtl/mul_hilo_stage_acc.sv
// Combinational 64-bit pass/add/sub unit producing the next {hi, lo}.
// Signed and unsigned products share the adder; reserved ops leave acc unchanged.
module hilo_acc
  import mul_pkg::*;
(
  input  logic [63:0] acc,
  input  logic [63:0] p,
  input  logic [2:0]  op,
  output logic [63:0] result
);

  always_comb begin
    result = acc;
    if (is_reserved_op(op)) begin
      result = acc;
    end else if (is_acc_op(op)) begin
      result = acc + p;
    end else if (is_sub_op(op)) begin
      result = acc - p;
    end else begin
      result = p;
    end
  end

endmodule

// File: rtl/mul_hilo_stage.sv
// HI/LO commit stage behind the 32x32 multiplier: one-entry holding register
// with valid/ready, downstream hold, MTHI/MTLO writes and a commit counter.
module mul_hilo_stage
  import mul_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_z,
  input  logic [63:0]      in_y,
  input  logic [2:0]       in_op,
  input  logic             hold,
  input  logic             mthi_we,
  input  logic             mtlo_we,
  input  logic [31:0]      mt_data,
  output logic [31:0]      hi,
  output logic [31:0]      lo,
  output logic             busy,
  output logic             done,
  output logic             bad_op,
  output logic [CNT_W-1:0] commit_cnt
);

  // Handshake: a transfer happens on a rising edge where in_valid and in_ready
  // are both high; in_ready does not depend on in_valid, and a producer whose
  // offer is not taken keeps in_valid and its payload stable.
  slot_state_t state_q, state_d;
  prod_t       ent_p;
  op_t         ent_op;
  logic [63:0] acc_res;
  logic        commit_en;
  logic        accept;

  assign busy      = (state_q == ST_FULL);
  assign commit_en = busy & ~hold & ~mthi_we & ~mtlo_we;
  assign in_ready  = rst & (~busy | commit_en);
  assign accept    = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (accept) state_d = ST_FULL;
      ST_FULL:  if (commit_en && !accept) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  hilo_acc u_acc (
    .acc    ({hi, lo}),
    .p      (ent_p),
    .op     (ent_op),
    .result (acc_res)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_EMPTY;
      ent_p      <= '0;
      ent_op     <= '0;
      hi         <= '0;
      lo         <= '0;
      done       <= 1'b0;
      bad_op     <= 1'b0;
      commit_cnt <= '0;
    end else begin
      state_q <= state_d;
      done    <= commit_en;
      if (accept) begin
        ent_p  <= is_signed_op(in_op) ? in_z : in_y;
        ent_op <= in_op;
        if (is_reserved_op(in_op)) bad_op <= 1'b1;
      end
      // MTHI/MTLO suppress commit_en, so the two write paths never collide.
      if (commit_en) begin
        {hi, lo}   <= acc_res;
        commit_cnt <= commit_cnt + CNT_W'(1);
      end else begin
        if (mthi_we) hi <= mt_data;
        if (mtlo_we) lo <= mt_data;
      end
    end
  end

endmodule

// File: tb/tb_mul_hilo_stage.sv
// Self-checking bench for mul_hilo_stage: directed scenarios then random
// traffic, checked each cycle against a queue-based behavioural model.
module tb_mul_hilo_stage;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [63:0]      in_z = '0;
  logic [63:0]      in_y = '0;
  logic [2:0]       in_op = '0;
  logic             hold = 1'b0;
  logic             mthi_we = 1'b0;
  logic             mtlo_we = 1'b0;
  logic [31:0]      mt_data = '0;
  logic [31:0]      hi;
  logic [31:0]      lo;
  logic             busy;
  logic             done;
  logic             bad_op;
  logic [CNT_W-1:0] commit_cnt;

  mul_hilo_stage #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_z       (in_z),
    .in_y       (in_y),
    .in_op      (in_op),
    .hold       (hold),
    .mthi_we    (mthi_we),
    .mtlo_we    (mtlo_we),
    .mt_data    (mt_data),
    .hi         (hi),
    .lo         (lo),
    .busy       (busy),
    .done       (done),
    .bad_op     (bad_op),
    .commit_cnt (commit_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Pending entries as {op, selected product}; at most one is ever held.
  logic [66:0]      exp_q[$];
  logic [63:0]      m_acc = '0;
  logic             m_done = 1'b0;
  logic             m_bad = 1'b0;
  logic [CNT_W-1:0] m_cnt = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at the falling edge, check in_ready, advance the
  // model at the rising edge, check registered outputs at the next falling edge.
  task automatic cycle(input logic v, input logic [2:0] op, input logic [63:0] z,
                       input logic [63:0] y, input logic h, input logic mhi,
                       input logic mlo, input logic [31:0] md, input logic r);
    logic        exp_ready;
    logic        commit;
    logic [66:0] e;
    logic [63:0] p;
    in_valid = v; in_op = op; in_z = z; in_y = y;
    hold = h; mthi_we = mhi; mtlo_we = mlo; mt_data = md; rst = r;
    exp_ready = r && (exp_q.size() == 0 || (!h && !mhi && !mlo));
    #1;
    check("in_ready", 64'(in_ready), 64'(exp_ready));
    @(posedge clk);
    if (!r) begin
      exp_q.delete();
      m_acc = '0; m_done = 1'b0; m_bad = 1'b0; m_cnt = '0;
    end else begin
      commit = exp_q.size() > 0 && !h && !mhi && !mlo;
      if (mhi) m_acc[63:32] = md;
      if (mlo) m_acc[31:0] = md;
      m_done = commit;
      if (commit) begin
        e = exp_q.pop_front();
        p = e[63:0];
        case (e[66:64])
          3'd0, 3'd1: m_acc = p;
          3'd2, 3'd3: m_acc = m_acc + p;
          3'd4, 3'd5: m_acc = m_acc - p;
          default: ;
        endcase
        m_cnt = m_cnt + 1'b1;
      end
      if (v && exp_ready) begin
        exp_q.push_back({op, (op == 3'd0 || op == 3'd2 || op == 3'd4) ? z : y});
        if (op > 3'd5) m_bad = 1'b1;
      end
    end
    @(negedge clk);
    check("hi", 64'(hi), 64'(m_acc[63:32]));
    check("lo", 64'(lo), 64'(m_acc[31:0]));
    check("busy", 64'(busy), 64'(exp_q.size() != 0));
    check("done", 64'(done), 64'(m_done));
    check("bad_op", 64'(bad_op), 64'(m_bad));
    check("commit_cnt", 64'(commit_cnt), 64'(m_cnt));
  endtask

  task automatic go(input logic v, input logic [2:0] op, input logic [63:0] z, input logic [63:0] y);
    cycle(v, op, z, y, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic idle();
    go(1'b0, 3'd0, 64'h0, 64'h0);
  endtask

  initial begin
    @(negedge clk);

    // Reset held two cycles with a valid offer present.
    cycle(1'b1, 3'd0, 64'h1234, 64'h5678, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 3'd1, 64'h1234, 64'h5678, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    check("rst_hilo", {32'h0, hi | lo}, 64'h0);
    idle();

    // MUL_S picks Z and ignores Y.
    go(1'b1, 3'd0, 64'hFFFFFFFF_FFFFFFFE, 64'h00000001_00000002);
    idle();
    check("mul_s_val", {hi, lo}, 64'hFFFFFFFF_FFFFFFFE);
    check("mul_s_done", 64'(done), 64'd1);
    idle();

    // MUL_U then back-to-back MADD_U wrapping mod 2^64.
    go(1'b1, 3'd1, 64'h0, 64'h00000001_00000002);
    go(1'b1, 3'd3, 64'h0, 64'hFFFFFFFF_FFFFFFFF);
    idle();
    check("madd_u_wrap", {hi, lo}, 64'h00000001_00000001);
    check("cnt_after_madd", 64'(commit_cnt), 64'd3);
    idle();

    // Hold with a second entry offered; it waits until the first commits.
    go(1'b1, 3'd1, 64'h0, 64'd5);
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 3'd3, 64'h0, 64'd7, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    check("hold_unchanged", {hi, lo}, 64'h00000001_00000001);
    go(1'b1, 3'd3, 64'h0, 64'd7);
    check("hold_first", {hi, lo}, 64'd5);
    idle();
    check("hold_second", {hi, lo}, 64'd12);

    // MTHI/MTLO defer a pending MSUB_S by a cycle.
    go(1'b1, 3'd4, 64'h00000000_00000001, 64'hDEAD);
    cycle(1'b0, 3'd0, 64'h0, 64'h0, 1'b0, 1'b1, 1'b1, 32'h00000010, 1'b1);
    check("mt_no_done", 64'(done), 64'd0);
    idle();
    check("msub_after_mt", {hi, lo}, 64'h00000010_0000000F);

    // Reserved op: sticky flag, no-op commit; then reset discards a FULL entry.
    go(1'b1, 3'd7, 64'h55, 64'h66);
    idle();
    check("rsvd_bad", 64'(bad_op), 64'd1);
    check("rsvd_hilo", {hi, lo}, 64'h00000010_0000000F);
    idle();
    go(1'b1, 3'd0, 64'h99, 64'h0);
    cycle(1'b0, 3'd0, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    check("rst_flush_busy", 64'(busy), 64'd0);
    idle();

    // Random traffic; enough commits to wrap the narrow counter several times.
    for (int i = 0; i < 500; i++) begin
      cycle(1'($urandom_range(0, 3) != 0),
            3'($urandom_range(0, 7)),
            {32'($urandom), 32'($urandom)},
            {32'($urandom), 32'($urandom)},
            1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 9) == 0),
            1'($urandom_range(0, 9) == 0),
            32'($urandom),
            1'($urandom_range(0, 49) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
